// File: rtl/fix_lut_seq_acc.sv
// Time-multiplexed fixed-point LUT accumulator.
// Each accepted control vector is summed as sum_j (sel[j] ? +fact[j] : -fact[j])
// by evaluating luts_per_cycle LUT segments per pass over P passes. The sum is
// kept at full width and saturated to the signed n_int.n_mant format on the
// last pass. Ready/valid handshakes are used on both sides.
module fix_lut_seq_acc #(
  parameter int size           = 24,
  parameter int lut_size       = 4,
  parameter int luts_per_cycle = 2,
  parameter int n_int          = 8,
  parameter int n_mant         = 23,
  parameter logic signed [size-1:0][n_int+n_mant:0] fact = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [size-1:0]         sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [n_int+n_mant:0]   result,
  output logic                    sat
);

  localparam int NSEG = (size + lut_size - 1) / lut_size;
  localparam int P    = (NSEG + luts_per_cycle - 1) / luts_per_cycle;
  localparam int N    = n_int + n_mant + 1;
  localparam int W    = (size == 1) ? N : N + $clog2(size);
  localparam int NPAD = P * luts_per_cycle;
  localparam int CW   = (P > 1) ? $clog2(P) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_OUTPUT
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [W-1:0]  acc_q, acc_d;
  logic [size-1:0]      sel_q, sel_d;
  logic [N-1:0]         result_q, result_d;
  logic                 sat_q, sat_d;

  logic signed [W-1:0]  seg_val [NPAD];
  logic signed [W-1:0]  pass_sum;
  logic signed [W-1:0]  total;
  logic                 fits;
  logic [N-1:0]         clip_val;
  logic                 accept;

  // One LUT entry: signed sum of the segment's coefficients, each added when
  // its control bit in idx is 1 and subtracted when 0. Exact in W bits.
  function automatic logic signed [W-1:0] lut_entry(input int base, input int ws, input int idx);
    logic signed [W-1:0] sum;
    logic signed [N-1:0] f;
    logic signed [W-1:0] fw;
    sum = '0;
    for (int j = 0; j < ws; j++) begin
      f  = fact[base + j];
      fw = f;
      if (((idx >> j) & 1) != 0) begin
        sum = sum + fw;
      end else begin
        sum = sum - fw;
      end
    end
    return sum;
  endfunction

  genvar gi, ei;

  // Segment LUTs, addressed by the captured control vector. Segments past the
  // last real one are padding so every pass reads luts_per_cycle values.
  generate
    for (gi = 0; gi < NPAD; gi++) begin : g_seg
      if (gi < NSEG) begin : g_live
        localparam int BASE = gi * lut_size;
        localparam int WS   = ((size - BASE) < lut_size) ? (size - BASE) : lut_size;
        logic signed [W-1:0] lut [2**WS];
        for (ei = 0; ei < 2**WS; ei++) begin : g_ent
          assign lut[ei] = lut_entry(BASE, WS, ei);
        end
        assign seg_val[gi] = lut[sel_q[BASE +: WS]];
      end else begin : g_pad
        assign seg_val[gi] = '0;
      end
    end
  endgenerate

  // Sum of the segments belonging to the current pass.
  always_comb begin
    pass_sum = '0;
    for (int k = 0; k < P; k++) begin
      if (cnt_q == CW'(k)) begin
        for (int g = 0; g < luts_per_cycle; g++) begin
          pass_sum = pass_sum + seg_val[k * luts_per_cycle + g];
        end
      end
    end
  end

  // Running total and saturation test: the value fits in N bits when all
  // bits from the N-bit sign position upward agree.
  always_comb begin
    total    = acc_q + pass_sum;
    fits     = (&total[W-1:N-1]) | ~(|total[W-1:N-1]);
    clip_val = total[W-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  end

  assign in_ready  = ~rst & ((state_q == S_IDLE) | ((state_q == S_OUTPUT) & out_ready));
  assign out_valid = (state_q == S_OUTPUT);
  assign result    = result_q;
  assign sat       = sat_q;
  assign accept    = in_valid & in_ready;

  // Next-state and datapath updates for the accept / accumulate / output cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    sel_d    = sel_q;
    result_d = result_q;
    sat_d    = sat_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sel_d   = sel;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (cnt_q == CW'(P - 1)) begin
          result_d = fits ? total[N-1:0] : clip_val;
          sat_d    = ~fits;
          state_d  = S_OUTPUT;
        end else begin
          acc_d = total;
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          if (in_valid) begin
            sel_d   = sel;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_ACCUM;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset discards any sample in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      sel_q    <= '0;
      result_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      sel_q    <= sel_d;
      result_q <= result_d;
      sat_q    <= sat_d;
    end
  end

endmodule
